game_flow_ctl: RTL and testbench

Top-level game sequencer for the Pong video pipeline. It decides which screen the output mux shows: title, game field or winner screen. It tracks both players' scores and holds the ball/paddle logic in reset between points. It also drives the player_won select consumed by the winner screen renderer. Timing is counted in video frames, derived from the vsync_in rising edge.

---
 rtl/game_flow_ctl.sv | 190 +++++++++++++++++++
 tb/tb_game_flow_ctl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctl.sv
// Pong game sequencer: picks the displayed screen, keeps both scores, holds the
// ball/paddle logic at the serve position between points and flags the winner.
// Time is measured in video frames, one frame per vsync_in rising edge.
module game_flow_ctl #(
   parameter int unsigned WIN_SCORE     = 5,
   parameter int unsigned SCORE_W       = 4,
   parameter int unsigned SERVE_FRAMES  = 60,
   parameter int unsigned WINNER_FRAMES = 300,
   parameter int unsigned FRAME_CNT_W   = 9
) (
   input  logic               pclk,
   input  logic               rst_n,
   input  logic               vsync_in,
   input  logic               start_btn,
   input  logic               goal_p1,
   input  logic               goal_p2,
   output logic [SCORE_W-1:0] score_p1,
   output logic [SCORE_W-1:0] score_p2,
   output logic               player_won,
   output logic [1:0]         screen_sel,
   output logic               ball_rst,
   output logic               game_active
);

   typedef enum logic [1:0] {
      StTitle = 2'd0,
      StServe = 2'd1,
      StPlay  = 2'd2,
      StWin   = 2'd3
   } state_e;

   localparam logic [1:0] ScreenTitle  = 2'd0;
   localparam logic [1:0] ScreenField  = 2'd1;
   localparam logic [1:0] ScreenWinner = 2'd2;

   localparam logic [SCORE_W-1:0]     WinScore  = SCORE_W'(WIN_SCORE);
   localparam logic [FRAME_CNT_W-1:0] ServeLast = FRAME_CNT_W'(SERVE_FRAMES - 1);
   localparam logic [FRAME_CNT_W-1:0] WinLast   = FRAME_CNT_W'(WINNER_FRAMES - 1);

   state_e                 state_q, state_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [SCORE_W-1:0]     score_p1_q, score_p1_d;
   logic [SCORE_W-1:0]     score_p2_q, score_p2_d;
   logic                   player_won_q, player_won_d;
   logic [1:0]             screen_sel_q, screen_sel_d;
   logic                   ball_rst_q, ball_rst_d;
   logic                   game_active_q, game_active_d;

   // Delayed copies for edge detection; reset high so a level already high at
   // reset release is not mistaken for an edge.
   logic vsync_q, start_q;
   logic frame_tick, start_edge;

   assign frame_tick = vsync_in & ~vsync_q;
   assign start_edge = start_btn & ~start_q;

   // Register the raw inputs for edge detection.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b1;
         start_q <= 1'b1;
      end else begin
         vsync_q <= vsync_in;
         start_q <= start_btn;
      end
   end

   // Next-state, frame counter and score update logic.
   always_comb begin
      state_d      = state_q;
      frame_cnt_d  = frame_cnt_q;
      score_p1_d   = score_p1_q;
      score_p2_d   = score_p2_q;
      player_won_d = player_won_q;

      case (state_q)
         StTitle: begin
            frame_cnt_d = '0;
            if (start_edge) begin
               state_d    = StServe;
               score_p1_d = '0;
               score_p2_d = '0;
            end
         end

         StServe: begin
            if (frame_tick) begin
               if (frame_cnt_q == ServeLast) begin
                  state_d     = StPlay;
                  frame_cnt_d = '0;
               end else begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end
            end
         end

         StPlay: begin
            frame_cnt_d = '0;
            // goal_p1 wins a same-cycle tie; goal_p2 is dropped in that case.
            if (goal_p1) begin
               if (score_p1_q < WinScore) begin
                  score_p1_d = score_p1_q + 1'b1;
               end
               if (score_p1_d == WinScore) begin
                  state_d      = StWin;
                  player_won_d = 1'b0;
               end else begin
                  state_d = StServe;
               end
            end else if (goal_p2) begin
               if (score_p2_q < WinScore) begin
                  score_p2_d = score_p2_q + 1'b1;
               end
               if (score_p2_d == WinScore) begin
                  state_d      = StWin;
                  player_won_d = 1'b1;
               end else begin
                  state_d = StServe;
               end
            end
         end

         StWin: begin
            if (frame_tick) begin
               if (frame_cnt_q == WinLast) begin
                  state_d     = StTitle;
                  frame_cnt_d = '0;
               end else begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d     = StTitle;
            frame_cnt_d = '0;
         end
      endcase
   end

   // Output values are decoded from the next state so they register together
   // with it, giving one cycle of latency from the triggering event.
   always_comb begin
      screen_sel_d  = ScreenTitle;
      ball_rst_d    = 1'b1;
      game_active_d = 1'b0;
      case (state_d)
         StTitle: screen_sel_d = ScreenTitle;
         StServe: screen_sel_d = ScreenField;
         StPlay: begin
            screen_sel_d  = ScreenField;
            ball_rst_d    = 1'b0;
            game_active_d = 1'b1;
         end
         StWin:   screen_sel_d = ScreenWinner;
         default: screen_sel_d = ScreenTitle;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StTitle;
         frame_cnt_q   <= '0;
         score_p1_q    <= '0;
         score_p2_q    <= '0;
         player_won_q  <= 1'b0;
         screen_sel_q  <= ScreenTitle;
         ball_rst_q    <= 1'b1;
         game_active_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         frame_cnt_q   <= frame_cnt_d;
         score_p1_q    <= score_p1_d;
         score_p2_q    <= score_p2_d;
         player_won_q  <= player_won_d;
         screen_sel_q  <= screen_sel_d;
         ball_rst_q    <= ball_rst_d;
         game_active_q <= game_active_d;
      end
   end

   assign score_p1    = score_p1_q;
   assign score_p2    = score_p2_q;
   assign player_won  = player_won_q;
   assign screen_sel  = screen_sel_q;
   assign ball_rst    = ball_rst_q;
   assign game_active = game_active_q;

endmodule

// File: tb/tb_game_flow_ctl.sv
// Scoreboard bench for game_flow_ctl: each stimulus cycle steps a game-level
// reference model and queues the expected outputs; a monitor compares them
// against the DUT just after the following clock edge.
module tb_game_flow_ctl;

   localparam int WIN_SCORE     = 5;
   localparam int SCORE_W       = 4;
   localparam int SERVE_FRAMES  = 60;
   localparam int WINNER_FRAMES = 300;
   localparam int FRAME_CNT_W   = 9;

   // Model modes
   localparam int MTitle = 0;
   localparam int MServe = 1;
   localparam int MPlay  = 2;
   localparam int MWin   = 3;

   logic               pclk = 1'b0;
   logic               rst_n;
   logic               vsync_in, start_btn, goal_p1, goal_p2;
   logic [SCORE_W-1:0] score_p1, score_p2;
   logic               player_won;
   logic [1:0]         screen_sel;
   logic               ball_rst, game_active;

   game_flow_ctl #(
      .WIN_SCORE    (WIN_SCORE),
      .SCORE_W      (SCORE_W),
      .SERVE_FRAMES (SERVE_FRAMES),
      .WINNER_FRAMES(WINNER_FRAMES),
      .FRAME_CNT_W  (FRAME_CNT_W)
   ) dut (
      .pclk       (pclk),
      .rst_n      (rst_n),
      .vsync_in   (vsync_in),
      .start_btn  (start_btn),
      .goal_p1    (goal_p1),
      .goal_p2    (goal_p2),
      .score_p1   (score_p1),
      .score_p2   (score_p2),
      .player_won (player_won),
      .screen_sel (screen_sel),
      .ball_rst   (ball_rst),
      .game_active(game_active)
   );

   always #5 pclk = ~pclk;

   int tests = 0;
   int fails = 0;

   // Reference model state
   int   m_mode, m_s1, m_s2, m_pw, m_frames_left;
   logic m_vs, m_st;

   logic [12:0] exp_q[$];
   logic        vs_r, st_r;

   function automatic logic [12:0] pack(input int s1, input int s2, input int pw,
                                        input int scr, input int br, input int ga);
      logic [12:0] v;
      v = {4'(s1), 4'(s2), 1'(pw), 2'(scr), 1'(br), 1'(ga)};
      return v;
   endfunction

   function automatic logic [12:0] model_out();
      int scr;
      scr = (m_mode == MTitle) ? 0 : ((m_mode == MWin) ? 2 : 1);
      return pack(m_s1, m_s2, m_pw, scr, (m_mode == MPlay) ? 0 : 1,
                  (m_mode == MPlay) ? 1 : 0);
   endfunction

   task automatic model_reset();
      m_mode = MTitle; m_s1 = 0; m_s2 = 0; m_pw = 0; m_frames_left = 0;
      m_vs = 1'b1; m_st = 1'b1;
   endtask

   // Game rules applied to one clock cycle of inputs.
   task automatic model_step(input logic vs, input logic st, input logic g1, input logic g2);
      bit tick, press;
      tick  = vs && !m_vs;
      press = st && !m_st;
      m_vs  = vs;
      m_st  = st;
      if (m_mode == MTitle) begin
         if (press) begin
            m_s1 = 0; m_s2 = 0;
            m_mode = MServe; m_frames_left = SERVE_FRAMES;
         end
      end else if (m_mode == MServe) begin
         if (tick) begin
            m_frames_left--;
            if (m_frames_left == 0) m_mode = MPlay;
         end
      end else if (m_mode == MPlay) begin
         if (g1 || g2) begin
            if (g1) m_s1++; else m_s2++;
            if (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE) begin
               m_mode = MWin; m_pw = g1 ? 0 : 1; m_frames_left = WINNER_FRAMES;
            end else begin
               m_mode = MServe; m_frames_left = SERVE_FRAMES;
            end
         end
      end else begin
         if (tick) begin
            m_frames_left--;
            if (m_frames_left == 0) m_mode = MTitle;
         end
      end
   endtask

   // Drive one cycle of inputs away from the active edge and queue the result.
   task automatic cycle(input logic vs, input logic st, input logic g1, input logic g2);
      @(negedge pclk);
      vsync_in = vs; start_btn = st; goal_p1 = g1; goal_p2 = g2;
      model_step(vs, st, g1, g2);
      exp_q.push_back(model_out());
   endtask

   task automatic idle();
      vs_r = ~vs_r;
      cycle(vs_r, st_r, 1'b0, 1'b0);
   endtask

   task automatic wait_mode(input int target, input int limit, input string name);
      int n = 0;
      while (m_mode != target && n < limit) begin
         idle();
         n++;
      end
      if (m_mode != target) begin
         tests++; fails++;
         $display("FAIL %s: timeout after %0d cycles, mode %0d required %0d",
                  name, n, m_mode, target);
      end
   endtask

   task automatic goal(input logic g1, input logic g2);
      vs_r = ~vs_r;
      cycle(vs_r, st_r, g1, g2);
   endtask

   task automatic press_start();
      st_r = 1'b0; idle();
      st_r = 1'b1; idle();
   endtask

   task automatic drain();
      @(posedge pclk);
      #2;
   endtask

   task automatic check_now(input logic [12:0] exp, input string name);
      logic [12:0] act;
      act = {score_p1, score_p2, player_won, screen_sel, ball_rst, game_active};
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %013b required %013b", name, act, exp);
      end
   endtask

   // Monitor: compare each queued expectation just after the clock edge.
   initial begin
      logic [12:0] exp, act;
      forever begin
         @(posedge pclk);
         #1;
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            act = {score_p1, score_p2, player_won, screen_sel, ball_rst, game_active};
            tests++;
            if (act !== exp) begin
               fails++;
               $display("FAIL cycle_check t=%0t: got s1=%0d s2=%0d pw=%0b scr=%0d br=%0b ga=%0b required s1=%0d s2=%0d pw=%0b scr=%0d br=%0b ga=%0b",
                        $time, act[12:9], act[8:5], act[4], act[3:2], act[1], act[0],
                        exp[12:9], exp[8:5], exp[4], exp[3:2], exp[1], exp[0]);
            end
         end
      end
   end

   initial begin
      logic [12:0] rst_vals;
      rst_vals = pack(0, 0, 0, 0, 1, 0);

      // Reset with start and vsync already high: no edge on release.
      rst_n = 1'b0; vsync_in = 1'b1; start_btn = 1'b1; goal_p1 = 1'b0; goal_p2 = 1'b0;
      vs_r = 1'b1; st_r = 1'b1;
      model_reset();
      repeat (3) @(negedge pclk);
      check_now(rst_vals, "reset_values");
      rst_n = 1'b1;
      repeat (10) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      drain();
      check_now(rst_vals, "no_spurious_serve");

      // Start, serve countdown, first point to player 2.
      vs_r = 1'b1;
      press_start();
      wait_mode(MPlay, 4 * SERVE_FRAMES, "serve_to_play");
      repeat (3) idle();
      goal(1'b0, 1'b1);
      goal(1'b1, 1'b0); // ignored during serve
      repeat (3) idle();

      // Player 1 takes five points and wins.
      for (int i = 0; i < WIN_SCORE; i++) begin
         wait_mode(MPlay, 4 * SERVE_FRAMES, "p1_serve");
         goal(1'b1, 1'b0);
      end
      repeat (4) idle();
      press_start(); // ignored in WIN
      wait_mode(MTitle, 4 * WINNER_FRAMES, "win_to_title");
      repeat (5) idle();
      press_start();
      repeat (3) idle();

      // Reach 4:4, then simultaneous goals: player 1 must take it.
      for (int i = 0; i < WIN_SCORE - 1; i++) begin
         wait_mode(MPlay, 4 * SERVE_FRAMES, "tie_serve_a");
         goal(1'b1, 1'b0);
         wait_mode(MPlay, 4 * SERVE_FRAMES, "tie_serve_b");
         goal(1'b0, 1'b1);
      end
      wait_mode(MPlay, 4 * SERVE_FRAMES, "tie_serve_c");
      goal(1'b1, 1'b1);
      repeat (10) idle();

      // Asynchronous reset in the middle of WIN, between clock edges.
      drain();
      @(negedge pclk);
      #2;
      rst_n = 1'b0;
      #1;
      check_now(rst_vals, "async_reset_mid_win");
      vsync_in = 1'b1; start_btn = 1'b1; goal_p1 = 1'b0; goal_p2 = 1'b0;
      vs_r = 1'b1; st_r = 1'b1;
      model_reset();
      repeat (2) @(negedge pclk);
      rst_n = 1'b1;
      repeat (3) idle();

      // Random play: goals arrive in every mode, start toggles occasionally.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) st_r = ~st_r;
         cycle(1'($urandom_range(0, 1)), st_r,
               ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0));
      end

      drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
